// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter feeding a single-entry registered signed ALU.
// The result register is a one-deep skid-free slot: it can drain and refill in the same cycle.
module alu_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s0_valid,
   output logic             s0_ready,
   input  logic [2:0]       s0_sel,
   input  logic [WIDTH-1:0] s0_a,
   input  logic [WIDTH-1:0] s0_b,
   input  logic             s1_valid,
   output logic             s1_ready,
   input  logic [2:0]       s1_sel,
   input  logic [WIDTH-1:0] s1_a,
   input  logic [WIDTH-1:0] s1_b,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_c,
   output logic             m_z,
   output logic             m_err,
   output logic             m_id,
   output logic [CNTW-1:0]  cnt0,
   output logic [CNTW-1:0]  cnt1
);

   typedef enum logic {EMPTY, FULL} state_t;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q;
   logic             ptr_q, m_z_q, m_err_q, m_id_q;
   logic [WIDTH-1:0] m_c_q;
   logic [CNTW-1:0]  cnt0_q, cnt1_q;

   logic free, drain, gnt0, gnt1, accept;

   assign free   = (state_q == EMPTY) | m_ready;
   assign drain  = (state_q == FULL) & m_ready;
   assign gnt0   = !rst & free & s0_valid & (!s1_valid | !ptr_q);
   assign gnt1   = !rst & free & s1_valid & (!s0_valid | ptr_q);
   assign accept = gnt0 | gnt1;

   assign s0_ready = gnt0;
   assign s1_ready = gnt1;

   // Operand mux follows the grant so the ALU sees only the winning command.
   logic [2:0]              op_sel;
   logic signed [WIDTH-1:0] op_a, op_b, c_d;
   logic                    err_d, ovf;

   assign op_sel = gnt1 ? s1_sel : s0_sel;
   assign op_a   = gnt1 ? s1_a   : s0_a;
   assign op_b   = gnt1 ? s1_b   : s0_b;
   assign ovf    = (op_a == MOST_NEG) && (op_b == '1);

   always_comb begin
      c_d   = '0;
      err_d = 1'b0;
      case (op_sel)
         3'b000: c_d = op_a + op_b;
         3'b001: c_d = op_a - op_b;
         3'b010: c_d = op_a * op_b;
         3'b011: begin
            if (op_b == '0) err_d = 1'b1;
            else if (ovf)   c_d = MOST_NEG;
            else            c_d = op_a / op_b;
         end
         3'b100: begin
            // Overflow case is handled explicitly; its remainder is exactly zero.
            if (op_b == '0) err_d = 1'b1;
            else if (!ovf)  c_d = op_a % op_b;
         end
         default: c_d = op_a;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         ptr_q   <= 1'b0;
         m_c_q   <= '0;
         m_z_q   <= 1'b0;
         m_err_q <= 1'b0;
         m_id_q  <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         if (drain && !m_id_q) cnt0_q <= cnt0_q + 1'b1;
         if (drain &&  m_id_q) cnt1_q <= cnt1_q + 1'b1;
         if (accept) begin
            state_q <= FULL;
            ptr_q   <= gnt0;
            m_c_q   <= c_d;
            m_z_q   <= (c_d == '0);
            m_err_q <= err_d;
            m_id_q  <= gnt1;
         end else if (drain) begin
            state_q <= EMPTY;
         end
      end
   end

   assign m_valid = (state_q == FULL);
   assign m_c     = m_c_q;
   assign m_z     = m_z_q;
   assign m_err   = m_err_q;
   assign m_id    = m_id_q;
   assign cnt0    = cnt0_q;
   assign cnt1    = cnt1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration order, arithmetic corner cases, stall, reset, counter wrap.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       s0_valid, s1_valid, m_ready;
   logic       s0_ready, s1_ready;
   logic [2:0] s0_sel, s1_sel;
   logic [7:0] s0_a, s0_b, s1_a, s1_b;
   logic       m_valid, m_z, m_err, m_id;
   logic [7:0] m_c, cnt0, cnt1;

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.WIDTH(8), .CNTW(8)) dut (
      .clk(clk), .rst(rst),
      .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_sel(s0_sel), .s0_a(s0_a), .s0_b(s0_b),
      .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_sel(s1_sel), .s1_a(s1_a), .s1_b(s1_b),
      .m_valid(m_valid), .m_ready(m_ready), .m_c(m_c), .m_z(m_z), .m_err(m_err), .m_id(m_id),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   task automatic drive0(input logic v, input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
      s0_valid = v; s0_sel = sel; s0_a = a; s0_b = b;
   endtask

   task automatic drive1(input logic v, input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
      s1_valid = v; s1_sel = sel; s1_a = a; s1_b = b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive0(1'b0, 3'd0, 8'd0, 8'd0);
      drive1(1'b0, 3'd0, 8'd0, 8'd0);
      m_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      m_ready = 1'b1;
      drive0(1'b1, 3'd0, 8'd1, 8'd1);
      drive1(1'b1, 3'd0, 8'd1, 8'd1);
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
      total++; if (m_c !== 8'd0)     begin bad++; $display("FAIL reset_m_c got=%0d want=0", m_c); end
      total++; if (m_z !== 1'b0)     begin bad++; $display("FAIL reset_m_z got=%0b want=0", m_z); end
      total++; if (m_err !== 1'b0)   begin bad++; $display("FAIL reset_m_err got=%0b want=0", m_err); end
      total++; if (m_id !== 1'b0)    begin bad++; $display("FAIL reset_m_id got=%0b want=0", m_id); end
      total++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", cnt0, cnt1); end
      total++; if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b%0b want=00", s0_ready, s1_ready); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp_c;
      logic       exp_id;
      do_reset();
      m_ready = 1'b1;
      drive0(1'b1, 3'b000, 8'd5, 8'd3);
      drive1(1'b1, 3'b001, 8'd5, 8'd3);
      for (int i = 0; i < 6; i++) begin
         exp_id = i[0];
         exp_c  = exp_id ? 8'd2 : 8'd8;
         #1;
         total++; if (s0_ready !== !exp_id || s1_ready !== exp_id) begin bad++; $display("FAIL rr_grant[%0d] got=%0b%0b want_id=%0d", i, s0_ready, s1_ready, exp_id); end
         @(posedge clk); #1;
         total++; if (m_valid !== 1'b1 || m_c !== exp_c || m_id !== exp_id) begin bad++; $display("FAIL rr_result[%0d] got v=%0b c=%0d id=%0b want c=%0d id=%0b", i, m_valid, m_c, m_id, exp_c, exp_id); end
         @(negedge clk);
      end
      drive0(1'b0, 3'd0, 8'd0, 8'd0);
      drive1(1'b0, 3'd0, 8'd0, 8'd0);
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rr_drain_valid got=%0b want=0", m_valid); end
      total++; if (cnt0 !== 8'd3 || cnt1 !== 8'd3) begin bad++; $display("FAIL rr_counts got=%0d/%0d want=3/3", cnt0, cnt1); end
   endtask

   task automatic test_arith();
      logic [2:0] sel_t [8];
      logic [7:0] a_t [8], b_t [8], c_t [8];
      logic       z_t [8], e_t [8];
      sel_t = '{3'b011, 3'b100, 3'b010, 3'b011, 3'b011, 3'b001, 3'b101, 3'b000};
      a_t   = '{8'd7,   8'hF9,  8'd16,  8'h80,  8'hF9,  8'h80,  8'd9,   8'd127};
      b_t   = '{8'd0,   8'd2,   8'd16,  8'hFF,  8'd2,   8'd1,   8'd4,   8'd1};
      c_t   = '{8'd0,   8'hFF,  8'd0,   8'h80,  8'hFD,  8'h7F,  8'd9,   8'h80};
      z_t   = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
      e_t   = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
      do_reset();
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive0(1'b1, sel_t[i], a_t[i], b_t[i]);
         @(posedge clk); #1;
         total++; if (m_c !== c_t[i] || m_z !== z_t[i] || m_err !== e_t[i] || m_id !== 1'b0) begin bad++; $display("FAIL arith[%0d] got c=%0h z=%0b e=%0b id=%0b want c=%0h z=%0b e=%0b id=0", i, m_c, m_z, m_err, m_id, c_t[i], z_t[i], e_t[i]); end
         @(negedge clk);
      end
      drive0(1'b0, 3'd0, 8'd0, 8'd0);
   endtask

   task automatic test_stall();
      do_reset();
      m_ready = 1'b0;
      drive0(1'b1, 3'b000, 8'd5, 8'd3);
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b1 || m_c !== 8'd8) begin bad++; $display("FAIL stall_first got v=%0b c=%0d want v=1 c=8", m_valid, m_c); end
      @(negedge clk);
      drive0(1'b0, 3'd0, 8'd0, 8'd0);
      drive1(1'b1, 3'b001, 8'd9, 8'd2);
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (s1_ready !== 1'b0 || m_valid !== 1'b1 || m_c !== 8'd8 || m_id !== 1'b0) begin bad++; $display("FAIL stall_hold[%0d] got rdy=%0b v=%0b c=%0d id=%0b want rdy=0 v=1 c=8 id=0", i, s1_ready, m_valid, m_c, m_id); end
         @(negedge clk);
      end
      m_ready = 1'b1;
      #1;
      total++; if (s1_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%0b want=1", s1_ready); end
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b1 || m_c !== 8'd7 || m_id !== 1'b1 || cnt0 !== 8'd1) begin bad++; $display("FAIL stall_next got v=%0b c=%0d id=%0b cnt0=%0d want v=1 c=7 id=1 cnt0=1", m_valid, m_c, m_id, cnt0); end
      @(negedge clk);
      drive1(1'b0, 3'd0, 8'd0, 8'd0);
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b0 || cnt1 !== 8'd1) begin bad++; $display("FAIL stall_drain got v=%0b cnt1=%0d want v=0 cnt1=1", m_valid, cnt1); end
   endtask

   task automatic test_reset_pending();
      do_reset();
      m_ready = 1'b1;
      drive0(1'b1, 3'b000, 8'd1, 8'd1);
      repeat (6) @(posedge clk);
      @(negedge clk);
      m_ready = 1'b0;
      drive0(1'b0, 3'd0, 8'd0, 8'd0);
      #1;
      total++; if (m_valid !== 1'b1 || cnt0 !== 8'd5) begin bad++; $display("FAIL rstp_setup got v=%0b cnt0=%0d want v=1 cnt0=5", m_valid, cnt0); end
      rst = 1'b1;
      #1;
      total++; if (m_valid !== 1'b0 || cnt0 !== 8'd0 || m_c !== 8'd0) begin bad++; $display("FAIL rstp_async got v=%0b cnt0=%0d c=%0d want 0/0/0", m_valid, cnt0, m_c); end
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b1;
      drive0(1'b1, 3'b101, 8'd33, 8'd0);
      drive1(1'b1, 3'b101, 8'd44, 8'd0);
      #1;
      total++; if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin bad++; $display("FAIL rstp_ptr got=%0b%0b want=10", s0_ready, s1_ready); end
      @(posedge clk); #1;
      total++; if (m_valid !== 1'b1 || m_id !== 1'b0 || m_c !== 8'd33 || cnt0 !== 8'd0) begin bad++; $display("FAIL rstp_first got v=%0b id=%0b c=%0d cnt0=%0d want v=1 id=0 c=33 cnt0=0", m_valid, m_id, m_c, cnt0); end
      @(negedge clk);
      drive0(1'b0, 3'd0, 8'd0, 8'd0);
      drive1(1'b0, 3'd0, 8'd0, 8'd0);
   endtask

   task automatic test_wrap();
      do_reset();
      m_ready = 1'b1;
      drive0(1'b1, 3'b000, 8'd2, 8'd2);
      repeat (256) @(posedge clk);
      @(negedge clk);
      total++; if (cnt0 !== 8'd255) begin bad++; $display("FAIL wrap_pre got=%0d want=255", cnt0); end
      drive0(1'b0, 3'd0, 8'd0, 8'd0);
      @(posedge clk); #1;
      total++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0 || m_valid !== 1'b0) begin bad++; $display("FAIL wrap_post got cnt0=%0d cnt1=%0d v=%0b want 0/0/0", cnt0, cnt1, m_valid); end
   endtask

   initial begin
      rst = 1'b1;
      m_ready = 1'b0;
      drive0(1'b0, 3'd0, 8'd0, 8'd0);
      drive1(1'b0, 3'd0, 8'd0, 8'd0);
      test_reset();
      test_round_robin();
      test_arith();
      test_stall();
      test_reset_pending();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (signed two's complement).
REQ-002 SHALL have parameter CNTW, default 8, width of per-requester completion counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 s0_valid  input  1  requester 0 command valid.
REQ-006 s0_ready  output  1  requester 0 command accepted this cycle when high with s0_valid.
REQ-007 s0_sel  input  3  requester 0 opcode.
REQ-008 s0_a, s0_b  input  WIDTH each  requester 0 signed operands.
REQ-009 s1_valid, s1_ready, s1_sel, s1_a, s1_b  same directions/widths as s0_*, for requester 1.
REQ-010 m_valid  output  1  result register holds an unconsumed result.
REQ-011 m_ready  input  1  consumer accepts result when high with m_valid.
REQ-012 m_c  output  WIDTH  signed result.
REQ-013 m_z  output  1  high when m_c == 0.
REQ-014 m_err  output  1  divide/modulo by zero flag.
REQ-015 m_id  output  1  requester index that issued the result.
REQ-016 cnt0, cnt1  output  CNTW each  results delivered (m_valid & m_ready) per requester.

Function
REQ-017 Opcodes SHALL be: 000 A+B, 001 A-B, 010 A*B, 011 A/B, 100 A%B, 101-111 pass A.
REQ-018 All results SHALL be truncated to the low WIDTH bits (wrap, no saturation); division SHALL truncate toward zero, remainder takes sign of A.
REQ-019 Opcode 011 or 100 with B == 0 SHALL yield m_c = 0, m_err = 1, m_z = 1; all other cases m_err = 0.
REQ-020 Signed overflow divide (most-negative / -1) SHALL yield most-negative value, m_err = 0.
REQ-021 Slot free condition: free = !m_valid | m_ready.
REQ-022 Grant SHALL go only to a requester with valid high; only one of s0_ready/s1_ready SHALL be high per cycle; ready SHALL be low when free is low.
REQ-023 s*_ready SHALL be combinational from valids, free and priority pointer; SHALL NOT depend on m_* data.
REQ-024 Arbitration SHALL be round-robin: 1-bit pointer names preferred requester; when both valid, preferred wins; when one valid, it wins regardless of pointer.
REQ-025 Pointer SHALL update only on an accepted command, to the index opposite the winner.
REQ-026 On acceptance, m_c/m_z/m_err/m_id SHALL be registered and m_valid SHALL be high the next cycle (latency 1).
REQ-027 Throughput SHALL be one command per cycle when m_ready held high (drain and accept same cycle).
REQ-028 While m_valid & !m_ready, m_c/m_z/m_err/m_id SHALL remain stable.
REQ-029 m_valid SHALL fall the cycle after m_valid & m_ready with no acceptance in that cycle.
REQ-030 Requester SHALL keep valid and operands stable until ready; block does not buffer unaccepted commands.
REQ-031 cntN SHALL increment by 1 on each cycle with m_valid & m_ready & m_id==N, wrapping from all-ones to 0.
REQ-032 State: EMPTY (m_valid=0) and FULL (m_valid=1); EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on stall or drain-with-accept.

Reset
REQ-033 rst high SHALL immediately force m_valid=0, m_c=0, m_z=0, m_err=0, m_id=0, cnt0=0, cnt1=0, pointer=0 (requester 0 preferred).
REQ-034 rst asserted with a result pending SHALL discard it; no count increment.
REQ-035 While rst high, s0_ready and s1_ready SHALL be 0.
REQ-036 First rising edge after rst deassert SHALL be able to accept a command.

Verification
REQ-037 Both valid after reset, s0 = (000, 5, 3), s1 = (001, 5, 3), m_ready=1 -> s0 granted first, m_c=8 id=0; next cycle s1 granted, m_c=2 id=1; alternation continues.
REQ-038 s0 = (011, 7, 0) -> m_c=0, m_err=1, m_z=1; s0 = (100, -7, 2) -> m_c=-1, m_err=0.
REQ-039 s0 = (010, 16, 16), WIDTH=8 -> m_c=0, m_z=1; s0 = (011, -128, -1) -> m_c=-128, m_err=0.
REQ-040 m_ready low 3 cycles with result 8 held, s1 valid -> m_c stable, s1_ready low; m_ready high -> s1 accepted same cycle, new result next cycle.
REQ-041 rst pulse while m_valid=1 and cnt0=5 -> m_valid=0, cnt0=0 immediately, pointer back to requester 0.
REQ-042 256 consecutive s0 results drained with CNTW=8 -> cnt0 wraps to 0, cnt1 stays 0.
